// File: rtl/div_unit.sv
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle; fixed latency regardless of operands.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       DivSel,
    input  logic [WIDTH-1:0] DivA,
    input  logic [WIDTH-1:0] DivB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] DivOut
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t           r_state;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_out;
    logic             r_rem_op;
    logic             r_qsign;
    logic             r_rsign;
    logic             r_dz;
    logic             r_ovf;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_a_raw;
    logic [CNT_W-1:0] r_cnt;

    logic             w_signed;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_abs;
    logic [WIDTH-1:0] w_b_abs;
    logic             w_dz;
    logic             w_ovf;
    logic [WIDTH:0]   w_rem_sh;
    logic             w_ge;
    logic [WIDTH-1:0] w_sub;
    logic [WIDTH-1:0] w_result;

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    assign w_signed = ~DivSel[0];
    assign w_a_neg  = w_signed & DivA[WIDTH-1];
    assign w_b_neg  = w_signed & DivB[WIDTH-1];
    assign w_a_abs  = cond_neg(DivA, w_a_neg);
    assign w_b_abs  = cond_neg(DivB, w_b_neg);
    assign w_dz     = (DivB == '0);
    assign w_ovf    = w_signed & (DivA == MIN_NEG) & (DivB == '1);

    // The partial remainder is always below the divisor, so the low WIDTH bits
    // of the difference are exact whenever the subtraction is taken.
    assign w_rem_sh = {r_rem, r_dvd[WIDTH-1]};
    assign w_ge     = (w_rem_sh >= {1'b0, r_dvs});
    assign w_sub    = w_rem_sh[WIDTH-1:0] - r_dvs;

    always_comb begin
        w_result = '0;
        if (r_dz) begin
            w_result = r_rem_op ? r_a_raw : '1;
        end else if (r_ovf) begin
            w_result = r_rem_op ? '0 : MIN_NEG;
        end else if (r_rem_op) begin
            w_result = cond_neg(r_rem, r_rsign);
        end else begin
            w_result = cond_neg(r_dvd, r_qsign);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_out    <= '0;
            r_rem_op <= 1'b0;
            r_qsign  <= 1'b0;
            r_rsign  <= 1'b0;
            r_dz     <= 1'b0;
            r_ovf    <= 1'b0;
            r_dvd    <= '0;
            r_dvs    <= '0;
            r_rem    <= '0;
            r_a_raw  <= '0;
            r_cnt    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state  <= S_CALC;
                        r_busy   <= 1'b1;
                        r_rem_op <= DivSel[1];
                        r_qsign  <= w_a_neg ^ w_b_neg;
                        r_rsign  <= w_a_neg;
                        r_dz     <= w_dz;
                        r_ovf    <= w_ovf;
                        r_dvd    <= w_a_abs;
                        r_dvs    <= w_b_abs;
                        r_a_raw  <= DivA;
                        r_rem    <= '0;
                        r_cnt    <= CNT_W'(WIDTH);
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_CALC: begin
                    r_rem <= w_ge ? w_sub : w_rem_sh[WIDTH-1:0];
                    r_dvd <= {r_dvd[WIDTH-2:0], w_ge};
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_out   <= w_result;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_DONE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign DivOut = r_out;

endmodule
